// File: rtl/lzc_norm_seq_if.sv
// Operand/result handshake bundle for the sequential mantissa normalizer.
// The slave side is the normalizer and the master side is its user.
interface lzc_norm_seq_if #(
    parameter int WIDTH = 64,
    parameter int EXP_W = 12
);
    localparam int SW = $clog2(WIDTH) + 1;

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] man_i;
    logic [EXP_W-1:0] exp_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] man_o;
    logic [EXP_W-1:0] exp_o;
    logic [SW-1:0]    shamt_o;
    logic             zero_o;
    logic             uf_o;

    modport slave (
        input  valid_i, man_i, exp_i, ready_i,
        output ready_o, valid_o, man_o, exp_o, shamt_o, zero_o, uf_o
    );

    modport master (
        output valid_i, man_i, exp_i, ready_i,
        input  ready_o, valid_o, man_o, exp_o, shamt_o, zero_o, uf_o
    );
endinterface

// File: rtl/lzc_norm_seq.sv
// Multi-cycle mantissa normalizer: scans one CHUNK-wide slice per cycle MSB-first,
// then applies a single left shift clamped so the biased exponent never goes below 0.
module lzc_norm_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int EXP_W = 12
) (
    input logic           clk_i,
    input logic           rst_i,
    lzc_norm_seq_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int SW    = $clog2(WIDTH) + 1;
    localparam int CW    = $clog2(CHUNK) + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int MW    = (SW > EXP_W) ? SW : EXP_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [CW-1:0] lzc_chunk(input logic [CHUNK-1:0] v);
        logic [CW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int b = CHUNK - 1; b >= 0; b--) begin
            if (!hit) begin
                if (v[b]) hit = 1'b1;
                else      n   = n + CW'(1);
            end
        end
        return n;
    endfunction

    // The applied shift saturates at the exponent so the result becomes denormal, not negative.
    function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] acc, input logic [EXP_W-1:0] e);
        logic [MW-1:0] a;
        logic [MW-1:0] x;
        a = MW'(acc);
        x = MW'(e);
        return (a > x) ? SW'(x) : acc;
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_man;
    logic [EXP_W-1:0] r_exp;
    logic [IDX_W-1:0] r_idx;
    logic [SW-1:0]    r_acc;
    logic             r_valid_o;
    logic [WIDTH-1:0] r_man_o;
    logic [EXP_W-1:0] r_exp_o;
    logic [SW-1:0]    r_shamt_o;
    logic             r_zero_o;
    logic             r_uf_o;

    logic [CHUNK-1:0] w_chunk;
    logic [CW-1:0]    w_cnt;
    logic             w_chunk_zero;
    logic             w_last;
    logic [SW-1:0]    w_eff;
    logic             w_uf;

    always_comb begin
        w_chunk = '0;
        for (int c = 0; c < N; c++) begin
            if (r_idx == IDX_W'(c)) w_chunk = r_man[WIDTH-1-c*CHUNK -: CHUNK];
        end
    end

    assign w_cnt        = lzc_chunk(w_chunk);
    assign w_chunk_zero = (w_chunk == '0);
    assign w_last       = (r_idx == IDX_W'(N - 1));
    assign w_eff        = clamp_shift(r_acc, r_exp);
    assign w_uf         = (MW'(r_acc) > MW'(r_exp));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_man     <= '0;
            r_exp     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_valid_o <= 1'b0;
            r_man_o   <= '0;
            r_exp_o   <= '0;
            r_shamt_o <= '0;
            r_zero_o  <= 1'b0;
            r_uf_o    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_man   <= bus.man_i;
                        r_exp   <= bus.exp_i;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_chunk_zero && w_last) begin
                        r_man_o   <= '0;
                        r_exp_o   <= '0;
                        r_shamt_o <= '0;
                        r_zero_o  <= 1'b1;
                        r_uf_o    <= 1'b0;
                        r_valid_o <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_chunk_zero) begin
                        r_acc <= r_acc + SW'(CHUNK);
                        r_idx <= r_idx + IDX_W'(1);
                    end else begin
                        r_acc   <= r_acc + SW'(w_cnt);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_man_o   <= r_man << w_eff;
                    r_exp_o   <= r_exp - EXP_W'(w_eff);
                    r_shamt_o <= w_eff;
                    r_zero_o  <= 1'b0;
                    r_uf_o    <= w_uf;
                    r_valid_o <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        r_valid_o <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o = (r_state == S_IDLE) & ~rst_i;
    assign bus.valid_o = r_valid_o;
    assign bus.man_o   = r_man_o;
    assign bus.exp_o   = r_exp_o;
    assign bus.shamt_o = r_shamt_o;
    assign bus.zero_o  = r_zero_o;
    assign bus.uf_o    = r_uf_o;
endmodule
